// File: rtl/seven_segment_pkg.sv
// Segment codes and scan-rate helper for the multiplexed 7-segment driver.
// Codes are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package seven_segment_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Clock cycles each digit stays lit; never below one so the scan always advances.
  function automatic int ticks_per_digit(input int clk_per, input int refr_rate,
                                         input int num_seg);
    longint denom;
    longint q;
    denom = longint'(clk_per) * longint'(refr_rate) * longint'(num_seg);
    q = 64'sd1_000_000_000 / denom;
    if (q < 64'sd1) begin
      return 1;
    end
    return int'(q);
  endfunction

endpackage

// File: rtl/hex_to_cathode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_cathode
  import seven_segment_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK[6:0];
    case (hex)
      4'h0: seg_n = SEG_0[6:0];
      4'h1: seg_n = SEG_1[6:0];
      4'h2: seg_n = SEG_2[6:0];
      4'h3: seg_n = SEG_3[6:0];
      4'h4: seg_n = SEG_4[6:0];
      4'h5: seg_n = SEG_5[6:0];
      4'h6: seg_n = SEG_6[6:0];
      4'h7: seg_n = SEG_7[6:0];
      4'h8: seg_n = SEG_8[6:0];
      4'h9: seg_n = SEG_9[6:0];
      4'hA: seg_n = SEG_A[6:0];
      4'hB: seg_n = SEG_B[6:0];
      4'hC: seg_n = SEG_C[6:0];
      4'hD: seg_n = SEG_D[6:0];
      4'hE: seg_n = SEG_E[6:0];
      4'hF: seg_n = SEG_F[6:0];
      default: seg_n = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/seven_segment.sv
// Round-robin scan driver for a common-anode, active-low multi-digit display.
// Optional per-digit decimal point input enabled by macro SEVEN_SEGMENT_DP_EN.
module seven_segment
  import seven_segment_pkg::*;
#(
  parameter int NUM_SEGMENTS = 8,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [4*NUM_SEGMENTS-1:0] encoded,
`ifdef SEVEN_SEGMENT_DP_EN
  input  logic [NUM_SEGMENTS-1:0]   dp,
`endif
  output logic [NUM_SEGMENTS-1:0]   anode,
  output logic [7:0]                cathode
);

  localparam int DIGIT_TICKS = ticks_per_digit(CLK_PER, REFR_RATE, NUM_SEGMENTS);
  localparam int CNT_W       = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W       = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SEGMENTS - 1);

  logic [CNT_W-1:0]        tick_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [CNT_W-1:0]        tick_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic [3:0]              nib;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_SEGMENTS-1:0] anode_nxt;
  logic [7:0]              cathode_nxt;
  logic [NUM_SEGMENTS-1:0] anode_p1;
  logic [7:0]              cathode_p1;

  // Stage p0: dwell counter and active digit index
  always_comb begin
    tick_nxt = tick_p0 + CNT_W'(1);
    idx_nxt  = idx_p0;
    if (tick_p0 == TICK_LAST) begin
      tick_nxt = '0;
      idx_nxt  = (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
    end
  end

  always_comb begin
    nib = encoded[4*(NUM_SEGMENTS-1-int'(idx_p0)) +: 4];
  end

  hex_to_cathode u_dec (
    .hex   (nib),
    .seg_n (seg_n)
  );

  always_comb begin
`ifdef SEVEN_SEGMENT_DP_EN
    dp_n = ~dp[idx_p0];
`else
    dp_n = 1'b1;
`endif
    anode_nxt         = '1;
    anode_nxt[idx_p0] = 1'b0;
    cathode_nxt       = {dp_n, seg_n};
  end

  // Stage p1: anode and cathode registered together so a digit never shows its neighbour's code
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_p0    <= '0;
      idx_p0     <= '0;
      anode_p1   <= '1;
      cathode_p1 <= SEG_BLANK;
    end else begin
      tick_p0    <= tick_nxt;
      idx_p0     <= idx_nxt;
      anode_p1   <= anode_nxt;
      cathode_p1 <= cathode_nxt;
    end
  end

  assign anode   = anode_p1;
  assign cathode = cathode_p1;

endmodule

// File: tb/tb_seven_segment.sv
// Self-checking bench: a fast-scan instance (one cycle per digit) and a default-rate instance.
module tb_seven_segment;

  localparam int N         = 8;
  localparam int FAST_REFR = 12_500_000;
  localparam int DEF_TICKS = 12500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_f, rst_d;
  logic [31:0] enc_f, enc_d;
  logic [7:0]  anode_f, anode_d, cath_f, cath_d;
`ifdef SEVEN_SEGMENT_DP_EN
  logic [7:0]  dp_f, dp_d;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] seg_tab [16];

  typedef struct packed {
    logic        rst_before;
    logic [31:0] enc;
    logic [7:0]  anode;
    logic [7:0]  cath;
  } vec_t;
  vec_t vecs [17];

  seven_segment #(.NUM_SEGMENTS(N), .CLK_PER(10), .REFR_RATE(FAST_REFR)) dut_fast (
    .Clk     (clk),
    .Reset   (rst_f),
    .encoded (enc_f),
`ifdef SEVEN_SEGMENT_DP_EN
    .dp      (dp_f),
`endif
    .anode   (anode_f),
    .cathode (cath_f)
  );

  seven_segment dut_def (
    .Clk     (clk),
    .Reset   (rst_d),
    .encoded (enc_d),
`ifdef SEVEN_SEGMENT_DP_EN
    .dp      (dp_d),
`endif
    .anode   (anode_d),
    .cathode (cath_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          n;
    int          idx;
    logic [31:0] e;
    logic [7:0]  d;
    logic [7:0]  exp_a, exp_c;
    logic [3:0]  nib;
    bit          r;

    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vecs[0]  = '{1'b0, 32'h01234567, 8'hFE, 8'hC0};
    vecs[1]  = '{1'b0, 32'h01234567, 8'hFD, 8'hF9};
    vecs[2]  = '{1'b0, 32'h01234567, 8'hFB, 8'hA4};
    vecs[3]  = '{1'b0, 32'h01234567, 8'hF7, 8'hB0};
    vecs[4]  = '{1'b0, 32'h01234567, 8'hEF, 8'h99};
    vecs[5]  = '{1'b0, 32'h01234567, 8'hDF, 8'h92};
    vecs[6]  = '{1'b0, 32'h01234567, 8'hBF, 8'h82};
    vecs[7]  = '{1'b0, 32'h01234567, 8'h7F, 8'hF8};
    vecs[8]  = '{1'b0, 32'h01234567, 8'hFE, 8'hC0};
    vecs[9]  = '{1'b1, 32'h89ABCDEF, 8'hFE, 8'h80};
    vecs[10] = '{1'b0, 32'h89ABCDEF, 8'hFD, 8'h90};
    vecs[11] = '{1'b0, 32'h89ABCDEF, 8'hFB, 8'h88};
    vecs[12] = '{1'b0, 32'h89ABCDEF, 8'hF7, 8'h83};
    vecs[13] = '{1'b0, 32'h89ABCDEF, 8'hEF, 8'hC6};
    vecs[14] = '{1'b0, 32'h89ABCDEF, 8'hDF, 8'hA1};
    vecs[15] = '{1'b0, 32'h89ABCDEF, 8'hBF, 8'h86};
    vecs[16] = '{1'b0, 32'h89ABCDEF, 8'h7F, 8'h8E};

    rst_f = 1'b1;
    rst_d = 1'b1;
    enc_f = 32'h01234567;
    enc_d = 32'h01234567;
`ifdef SEVEN_SEGMENT_DP_EN
    dp_f = 8'h00;
    dp_d = 8'h00;
`endif

    // Reset held for two cycles
    tick();
    tick();
    check("rst_anode_fast", 32'(anode_f), 32'hFF);
    check("rst_cath_fast",  32'(cath_f),  32'hFF);
    check("rst_anode_def",  32'(anode_d), 32'hFF);
    check("rst_cath_def",   32'(cath_d),  32'hFF);

    // Directed scan tables
    rst_f = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst_before) begin
        rst_f = 1'b1;
        enc_f = vecs[i].enc;
        tick();
        check($sformatf("tbl%0d_rst_anode", i), 32'(anode_f), 32'hFF);
        rst_f = 1'b0;
      end
      enc_f = vecs[i].enc;
      tick();
      check($sformatf("tbl%0d_anode", i), 32'(anode_f), 32'(vecs[i].anode));
      check($sformatf("tbl%0d_cath", i),  32'(cath_f),  32'(vecs[i].cath));
    end

    // Reset while digit 5 is lit
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (anode_f != 8'hDF && cnt < 20);
    check("mid_reach_digit5", 32'(anode_f), 32'hDF);
    rst_f = 1'b1;
    tick();
    check("mid_rst_anode", 32'(anode_f), 32'hFF);
    check("mid_rst_cath",  32'(cath_f),  32'hFF);
    rst_f = 1'b0;
    tick();
    check("mid_release_anode", 32'(anode_f), 32'hFE);

    // Decimal point behaviour
    rst_f = 1'b1;
`ifdef SEVEN_SEGMENT_DP_EN
    dp_f = 8'h04;
`endif
    tick();
    check("dp_rst_bit", 32'(cath_f[7]), 32'h1);
    rst_f = 1'b0;
    for (int k = 0; k < 16; k++) begin
      enc_f = $urandom;
      tick();
`ifdef SEVEN_SEGMENT_DP_EN
      check($sformatf("dp_bit%0d", k), 32'(cath_f[7]), (anode_f == 8'hFB) ? 32'h0 : 32'h1);
`else
      check($sformatf("dp_bit%0d", k), 32'(cath_f[7]), 32'h1);
`endif
    end

    // Randomized traffic against the behavioural model, with occasional resets
    n = 0;
    for (int it = 0; it < 200; it++) begin
      r = (it == 0) || ($urandom_range(0, 15) == 0);
      e = $urandom;
      d = 8'($urandom);
      enc_f = e;
`ifdef SEVEN_SEGMENT_DP_EN
      dp_f = d;
`endif
      rst_f = r;
      tick();
      if (r) begin
        n = 0;
        exp_a = 8'hFF;
        exp_c = 8'hFF;
      end else begin
        n++;
        idx = (n - 1) % N;
        exp_a = ~(8'h01 << idx);
        nib = 4'((e >> (4 * (N - 1 - idx))) & 32'hF);
        exp_c = seg_tab[nib];
`ifdef SEVEN_SEGMENT_DP_EN
        if (d[idx]) exp_c = exp_c & 8'h7F;
`endif
      end
      check($sformatf("rnd%0d_anode", it), 32'(anode_f), 32'(exp_a));
      check($sformatf("rnd%0d_cath", it),  32'(cath_f),  32'(exp_c));
    end
    rst_f = 1'b0;

    // Default refresh rate: dwell time on digit 0
    rst_d = 1'b0;
    tick();
    check("def_first_anode", 32'(anode_d), 32'hFE);
    check("def_first_cath",  32'(cath_d),  32'hC0);
    cnt = 1;
    for (int k = 0; k < 13000; k++) begin
      tick();
      if (anode_d == 8'hFE) cnt++;
      else break;
    end
    check("def_dwell_cycles", 32'(cnt), 32'(DEF_TICKS));
    check("def_next_anode", 32'(anode_d), 32'hFD);
    check("def_next_cath",  32'(cath_d),  32'hF9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
